// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
// Requester-side bus of the shared-RAM arbiter. There is one instance per
// requester: A and B each have their own.
//   req    master -> slave  access request, held until gnt
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  word address
//   wdata  master -> slave  write data
//   gnt    slave -> master  1-cycle pulse: command accepted
//   rvalid slave -> master  1-cycle pulse: rdata carries fresh read data
//   rdata  slave -> master  last read data, held until the next read
// ----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Round-robin arbiter that lets two requesters (A, B) share one single-port
// RAM with a combinational read path. In IDLE the module takes the winner's
// command and pulses that requester's gnt. It then spends exactly one ACCESS
// cycle with the command on the RAM pins. For a read, the RAM data is
// captured at the end of ACCESS and rvalid is pulsed in the following cycle.
// Every output comes straight from a register.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   a_if, b_if requester buses (slave side)
//   ram_cs     RAM chip select (high only in ACCESS)
//   ram_wr     RAM write strobe (high only in ACCESS of a write)
//   ram_addr   RAM address; holds the last command while idle
//   ram_wdata  RAM write data; holds the last command while idle
//   ram_rdata  RAM read data, combinational from ram_addr
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      a_if,
    ram_arbiter_if.slave      b_if,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Each requester's inputs are collected into arrays indexed by port
    // (0 = A, 1 = B). The datapath then needs only one index and no
    // per-port copies.
    logic [1:0]        req;
    logic              we_in    [2];
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];

    assign req         = {b_if.req, a_if.req};
    assign we_in[0]    = a_if.we;
    assign we_in[1]    = b_if.we;
    assign addr_in[0]  = a_if.addr;
    assign addr_in[1]  = b_if.addr;
    assign wdata_in[0] = a_if.wdata;
    assign wdata_in[1] = b_if.wdata;

    // Registered outputs and command/arbitration state
    logic [1:0]        gnt_reg,    gnt_next;
    logic [1:0]        rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg  [2];
    logic [DATA_W-1:0] rdata_next [2];
    logic              cs_reg,     cs_next;
    logic              wr_reg,     wr_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic [DATA_W-1:0] wdata_reg,  wdata_next;
    logic              owner_reg,  owner_next;          // port that owns the access
    logic              last_grant_b_reg, last_grant_b_next;  // 1: B won last

    // Winner when IDLE and at least one request is present. If both request,
    // the port that did not win last time goes first.
    logic win_b;
    assign win_b = req[1] && (!req[0] || !last_grant_b_reg);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. It computes the values that the output registers load
    // at the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_next          = '0;
        rvalid_next       = '0;
        rdata_next        = rdata_reg;
        cs_next           = 1'b0;
        wr_next           = 1'b0;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        owner_next        = owner_reg;
        last_grant_b_next = last_grant_b_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next[win_b]   = 1'b1;
                    cs_next           = 1'b1;
                    wr_next           = we_in[win_b];
                    addr_next         = addr_in[win_b];
                    wdata_next        = wdata_in[win_b];
                    owner_next        = win_b;
                    last_grant_b_next = win_b;
                end
            end
            ACCESS: begin
                // wr_reg still holds the command type during ACCESS
                if (!wr_reg) begin
                    rvalid_next[owner_reg] = 1'b1;
                    rdata_next[owner_reg]  = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg          <= '0;
            rvalid_reg       <= '0;
            rdata_reg[0]     <= '0;
            rdata_reg[1]     <= '0;
            cs_reg           <= 1'b0;
            wr_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            owner_reg        <= 1'b0;
            last_grant_b_reg <= 1'b1;
        end else begin
            gnt_reg          <= gnt_next;
            rvalid_reg       <= rvalid_next;
            rdata_reg[0]     <= rdata_next[0];
            rdata_reg[1]     <= rdata_next[1];
            cs_reg           <= cs_next;
            wr_reg           <= wr_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            owner_reg        <= owner_next;
            last_grant_b_reg <= last_grant_b_next;
        end
    end

    assign a_if.gnt    = gnt_reg[0];
    assign b_if.gnt    = gnt_reg[1];
    assign a_if.rvalid = rvalid_reg[0];
    assign b_if.rvalid = rvalid_reg[1];
    assign a_if.rdata  = rdata_reg[0];
    assign b_if.rdata  = rdata_reg[1];
    assign ram_cs      = cs_reg;
    assign ram_wr      = wr_reg;
    assign ram_addr    = addr_reg;
    assign ram_wdata   = wdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
// Testbench for ram_arbiter. A behavioural RAM is attached to the RAM pins.
// Expected outputs come from a transaction-level reference model that holds
// its own copy of memory. Directed sequences are followed by randomized
// traffic, and all comparisons go through check_val.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    localparam int AW = 2;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_bus ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_bus ();

    logic          ram_cs, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_if      (a_bus),
        .b_if      (b_bus),
        .ram_cs    (ram_cs),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM with a combinational read path
    logic [DW-1:0] ram_mem [4] = '{default: '0};
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model. Each access is one transaction: it is granted at one
    // edge, uses the RAM during the following cycle, and completes at the
    // next edge.
    bit            m_busy;
    bit            m_port, m_we, m_last_b;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_gnt [2];
    bit            m_rvalid [2];
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] mem_ref [4] = '{default: '0};
    bit            prev_cs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_port = 0; m_we = 0; m_last_b = 1;
        m_addr = '0; m_wdata = '0; prev_cs = 0;
        for (int i = 0; i < 2; i++) begin
            m_gnt[i] = 0; m_rvalid[i] = 0; m_rdata[i] = '0;
        end
    endtask

    // One active clock edge, with the requests that are present at that edge
    task automatic model_edge();
        bit ra, rb, pb;
        ra = a_bus.req;
        rb = b_bus.req;
        for (int i = 0; i < 2; i++) begin
            m_gnt[i] = 0; m_rvalid[i] = 0;
        end
        if (m_busy) begin
            if (m_we) mem_ref[m_addr] = m_wdata;
            else begin
                m_rdata[m_port]  = mem_ref[m_addr];
                m_rvalid[m_port] = 1;
            end
            m_busy = 0;
        end else if (ra || rb) begin
            pb       = rb && (!ra || !m_last_b);
            m_port   = pb;
            m_we     = pb ? b_bus.we    : a_bus.we;
            m_addr   = pb ? b_bus.addr  : a_bus.addr;
            m_wdata  = pb ? b_bus.wdata : a_bus.wdata;
            m_gnt[pb] = 1;
            m_last_b = pb;
            m_busy   = 1;
        end
    endtask

    task automatic check_all();
        check_val("a_gnt",     a_bus.gnt,    m_gnt[0]);
        check_val("b_gnt",     b_bus.gnt,    m_gnt[1]);
        check_val("a_rvalid",  a_bus.rvalid, m_rvalid[0]);
        check_val("b_rvalid",  b_bus.rvalid, m_rvalid[1]);
        check_val("a_rdata",   a_bus.rdata,  m_rdata[0]);
        check_val("b_rdata",   b_bus.rdata,  m_rdata[1]);
        check_val("ram_cs",    ram_cs,       m_busy);
        check_val("ram_wr",    ram_wr,       m_busy && m_we);
        check_val("ram_addr",  ram_addr,     m_addr);
        check_val("ram_wdata", ram_wdata,    m_wdata);
        check_val("cs_back_to_back", ram_cs && prev_cs, 0);
        prev_cs = ram_cs;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check_all();
        $display("cycle %0d: req=%b%b gnt=%b%b rvalid=%b%b cs=%b wr=%b addr=%0d",
                 cyc, b_bus.req, a_bus.req, b_bus.gnt, a_bus.gnt,
                 b_bus.rvalid, a_bus.rvalid, ram_cs, ram_wr, ram_addr);
    endtask

    // The caller is 1 time unit after a rising edge. Reset is asserted
    // mid-cycle, and the outputs are checked before any further edge.
    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic release_reset();
        #2;
        rst_n = 1'b1;
    endtask

    // Random requester behaviour. A requester holds its command until it is
    // granted; after that it either presents a new command or goes idle.
    task automatic drive(input int pa, input int pb);
        if (!a_bus.req || a_bus.gnt) begin
            if (int'($urandom_range(99)) < pa) begin
                a_bus.req = 1'b1; a_bus.we = 1'($urandom);
                a_bus.addr = AW'($urandom); a_bus.wdata = DW'($urandom);
            end else a_bus.req = 1'b0;
        end
        if (!b_bus.req || b_bus.gnt) begin
            if (int'($urandom_range(99)) < pb) begin
                b_bus.req = 1'b1; b_bus.we = 1'($urandom);
                b_bus.addr = AW'($urandom); b_bus.wdata = DW'($urandom);
            end else b_bus.req = 1'b0;
        end
    endtask

    task automatic set_a(input bit r, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_bus.req = r; a_bus.we = w; a_bus.addr = ad; a_bus.wdata = d;
    endtask

    task automatic set_b(input bit r, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_bus.req = r; b_bus.we = w; b_bus.addr = ad; b_bus.wdata = d;
    endtask

    int b_grants;

    initial begin
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        release_reset();

        // Directed: A writes 3 to address 2, then A reads address 2
        set_a(1, 1, 2'd2, 2'd3);
        tick();
        check_val("t2_a_gnt_wr", a_bus.gnt, 1);
        check_val("t2_ram_wr", ram_wr, 1);
        set_a(0, 0, 2'd2, 2'd0);
        tick();
        set_a(1, 0, 2'd2, 2'd0);
        tick();
        set_a(0, 0, 2'd2, 2'd0);
        tick();
        check_val("t2_a_rvalid", a_bus.rvalid, 1);
        check_val("t2_a_rdata", a_bus.rdata, 3);

        // B writes 2 to address 1
        set_b(1, 1, 2'd1, 2'd2);
        tick();
        set_b(0, 0, 2'd1, 2'd0);
        tick();

        // Directed: after reset, A and B request together; A must win first
        assert_reset();
        tick();
        release_reset();
        set_a(1, 1, 2'd0, 2'd1);
        set_b(1, 0, 2'd1, 2'd0);
        tick();
        check_val("t3_a_first", a_bus.gnt, 1);
        check_val("t3_b_waits", b_bus.gnt, 0);
        a_bus.req = 1'b0;
        tick();
        tick();
        check_val("t3_b_next", b_bus.gnt, 1);
        b_bus.req = 1'b0;
        tick();
        check_val("t3_b_rvalid", b_bus.rvalid, 1);
        check_val("t3_b_rdata", b_bus.rdata, 2);

        // Both requesters held continuously for 8 accesses
        for (int i = 0; i < 16; i++) begin
            drive(100, 100);
            tick();
        end

        // Only B requests
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        tick();
        tick();
        b_grants = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 100);
            tick();
            if (b_bus.gnt) b_grants++;
        end
        check_val("t5_b_grants", b_grants, 10);

        // Reset during the ACCESS cycle of a read; both requests stay pending
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        tick();
        tick();
        set_b(1, 0, 2'd1, 2'd0);
        tick();                       // B granted; ACCESS of a read
        check_val("t6_b_gnt", b_bus.gnt, 1);
        set_a(1, 0, 2'd2, 2'd0);
        assert_reset();
        check_val("t6_cs_drop", ram_cs, 0);
        tick();
        check_val("t6_no_rvalid", b_bus.rvalid, 0);
        release_reset();
        tick();
        check_val("t6_a_regrant", a_bus.gnt, 1);
        check_val("t6_b_waits", b_bus.gnt, 0);

        // Random traffic, with a reset asserted mid-run
        for (int i = 0; i < 400; i++) begin
            drive(60, 60);
            if (i == 200) begin
                assert_reset();
                tick();
                release_reset();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
